dual_edge_sample_monitor: RTL

Parametrised storage-element block that captures a WIDTH-bit input on both clock edges, keeps a DEPTH-stage rising-edge history, and detects/counts cycles in which the input changed during the clock-low phase. It is the multi-bit, multi-stage successor to our single-bit latch/flip-flop comparison block. It sits beside data paths under test as a setup/hold-style monitor.

---
 rtl/dual_edge_sample_monitor_if.sv | 27 ++
 rtl/dual_edge_sample_monitor.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dual_edge_sample_monitor_if.sv
// Signal bundle for dual_edge_sample_monitor. The master drives the monitored
// data and controls, and the slave (the monitor) returns its captures and flags.
interface dual_edge_sample_monitor_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) ();
    logic                 en;
    logic                 clr;
    logic [WIDTH-1:0]     D;
    logic [WIDTH-1:0]     Q_pos;
    logic [WIDTH-1:0]     Q_neg;
    logic [WIDTH-1:0]     Q_dly;
    logic                 dly_valid;
    logic                 mismatch;
    logic [CNT_WIDTH-1:0] mismatch_cnt;
    logic                 cnt_sat;

    modport master (
        output en, clr, D,
        input  Q_pos, Q_neg, Q_dly, dly_valid, mismatch, mismatch_cnt, cnt_sat
    );

    modport slave (
        input  en, clr, D,
        output Q_pos, Q_neg, Q_dly, dly_valid, mismatch, mismatch_cnt, cnt_sat
    );
endinterface

// File: rtl/dual_edge_sample_monitor.sv
// Captures D on both clock edges, keeps a rising-edge history, and flags and
// counts cycles in which D changed while the clock was low.
module dual_edge_sample_monitor #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input logic                     clk,
    input logic                     rst,
    dual_edge_sample_monitor_if.slave bus
);
    localparam int                 FILL_W   = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(DEPTH);

    // Falling-edge domain
    logic [WIDTH-1:0] q_neg_q, q_neg_d;
    logic             neg_tog_q, neg_tog_d;

    // Rising-edge domain
    logic [WIDTH-1:0]     q_pos_q, q_pos_d;
    logic [WIDTH-1:0]     hist_q [DEPTH];
    logic [WIDTH-1:0]     hist_d [DEPTH];
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 dly_valid_q, dly_valid_d;
    logic                 mismatch_q, mismatch_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 neg_valid_q, neg_valid_d;
    logic                 last_tog_q, last_tog_d;
    logic                 neg_cap_s;
    logic                 neg_valid_eff_s;

    // Falling-edge capture; each capture flips neg_tog so the rising domain can see it
    always_comb begin
        q_neg_d   = q_neg_q;
        neg_tog_d = neg_tog_q;
        if (bus.en) begin
            q_neg_d   = bus.D;
            neg_tog_d = ~neg_tog_q;
        end else begin
            q_neg_d   = q_neg_q;
            neg_tog_d = neg_tog_q;
        end
    end

    // Falling-edge registers
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_neg_q   <= '0;
            neg_tog_q <= 1'b0;
        end else begin
            q_neg_q   <= q_neg_d;
            neg_tog_q <= neg_tog_d;
        end
    end

    // A toggle since the previous rising edge means one falling capture in the low phase;
    // neg_valid lives entirely in the rising domain so clr can drop it without a second driver.
    assign neg_cap_s       = neg_tog_q ^ last_tog_q;
    assign neg_valid_eff_s = neg_valid_q | neg_cap_s;

    // Rising-edge next state: clr beats en
    always_comb begin
        q_pos_d     = q_pos_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        dly_valid_d = dly_valid_q;
        mismatch_d  = 1'b0;
        cnt_d       = cnt_q;
        neg_valid_d = neg_valid_eff_s;
        last_tog_d  = neg_tog_q;
        if (bus.clr) begin
            cnt_d       = '0;
            neg_valid_d = 1'b0;
            dly_valid_d = 1'b0;
            fill_d      = '0;
        end else if (bus.en) begin
            q_pos_d   = bus.D;
            hist_d[0] = bus.D;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end else begin
                fill_d = fill_q;
            end
            dly_valid_d = (fill_d == FILL_MAX);
            mismatch_d  = neg_valid_eff_s & (bus.D != q_neg_q);
            if (mismatch_d && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            mismatch_d = 1'b0;
        end
    end

    // Rising-edge registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_pos_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            fill_q      <= '0;
            dly_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            cnt_q       <= '0;
            neg_valid_q <= 1'b0;
            last_tog_q  <= 1'b0;
        end else begin
            q_pos_q     <= q_pos_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            dly_valid_q <= dly_valid_d;
            mismatch_q  <= mismatch_d;
            cnt_q       <= cnt_d;
            neg_valid_q <= neg_valid_d;
            last_tog_q  <= last_tog_d;
        end
    end

    assign bus.Q_pos        = q_pos_q;
    assign bus.Q_neg        = q_neg_q;
    assign bus.Q_dly        = hist_q[DEPTH-1];
    assign bus.dly_valid    = dly_valid_q;
    assign bus.mismatch     = mismatch_q;
    assign bus.mismatch_cnt = cnt_q;
    assign bus.cnt_sat      = &cnt_q;
endmodule
